// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
//
// Purpose: shared definitions for the write-back arbiter slice. It holds the
// requester index constants, the request record type, the zero-register
// constant and a helper that turns a destination register into a
// per-register bit mask.
//
// Contents:
//   REQ_ALU / REQ_LSU / REQ_CSR : requester slot indices.
//   REG_ZERO                    : architectural zero register (never written).
//   WB_XLEN                     : reference data width of wb_req_t.
//   wb_req_t                    : {rd, data} write-back record.
//   rd_onehot()                 : 32-bit one-hot of rd, with bit 0 masked off.
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int WB_XLEN = 32;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

    // Writes to the zero register are dropped, so the zero register never
    // shows up in any per-register bookkeeping mask.
    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        logic [31:0] mask;
        mask = 32'd0;
        if (rd != REG_ZERO) begin
            mask[rd] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_grant.sv
// ---------------------------------------------------------------------------
// rr_grant
//
// Purpose: one-hot grant selection over a request vector. The search starts
// at requester 'ptr' and wraps around; the first active request found wins.
// With ptr held at zero this degenerates into plain fixed priority (lowest
// index wins), so the same block serves both arbitration policies.
//
// Parameters:
//   NUM_REQ : number of requesters.
//   PTR_W   : width of the starting-point pointer.
//
// Ports:
//   req   [NUM_REQ-1:0] in  : active requests.
//   ptr   [PTR_W-1:0]   in  : index at which the search starts (< NUM_REQ).
//   grant [NUM_REQ-1:0] out : one-hot grant, zero when no request is active.
// ---------------------------------------------------------------------------
module rr_grant #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Walk the requesters in priority order starting at ptr. The 'found'
    // flag keeps later candidates from adding a second grant bit.
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Purpose: arbitrates several write-back requesters onto a single register
// file write port. One request is accepted per cycle whenever any is
// pending; the accepted destination and data are registered and presented
// to the register file one cycle later. Writes to register 0 are accepted
// but never turn into a register-file write.
//
// Configuration macro:
//   WB_ARB_ROUND_ROBIN_EN
//     defined   : round-robin arbitration; after a grant to requester i the
//                 next search starts at i+1 (mod NUM_REQ). The pointer only
//                 moves on a transfer.
//     undefined : fixed priority, lowest index wins; no pointer state.
//
// Parameters:
//   NUM_REQ : number of requesters (2..4).
//   XLEN    : data width.
//
// Ports:
//   clk        in  : rising-edge clock.
//   reset      in  : asynchronous active-high reset.
//   req_valid  in  [NUM_REQ]      : requester i has a write-back pending.
//   req_rd     in  [NUM_REQ][5]   : destination register per requester.
//   req_data   in  [NUM_REQ][XLEN]: write-back data per requester.
//   req_ready  out [NUM_REQ]      : one-hot grant (combinational).
//   reg_write  out                : register-file write enable.
//   wb_sel     out [5]            : register-file write address.
//   wb_data    out [XLEN]         : register-file write data.
//   wb_pending out [32]           : per-register "granted, not yet written".
// ---------------------------------------------------------------------------
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][4:0]        req_rd,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           reg_write,
    output logic [4:0]                     wb_sel,
    output logic [XLEN-1:0]                wb_data,
    output logic [31:0]                    wb_pending
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic             transfer;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic [31:0]      pending_set;
    logic [31:0]      pending_clr;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_grant (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (req_ready)
    );

    // Any valid request always receives a grant in the same cycle, so a
    // transfer happens exactly when some requester is valid. The winning
    // requester's rd/data are picked with the one-hot grant.
    always_comb begin
        transfer = |req_valid;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_rd   = req_rd[i];
                sel_data = req_data[i];
            end
        end
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] grant_idx;

    // Binary index of the requester granted this cycle.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    // The next search begins just after the last winner, wrapping at
    // NUM_REQ. Idle cycles leave the pointer where it is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (transfer) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + PTR_W'(1);
            end
        end
    end
`else
    assign ptr = '0;
`endif

    // A register is marked pending at the edge that accepts its write and
    // unmarked at the edge that ends the cycle in which reg_write presents
    // it. Setting wins over clearing so back-to-back writes to the same
    // register keep the bit high.
    always_comb begin
        pending_set = transfer  ? rd_onehot(sel_rd) : 32'd0;
        pending_clr = reg_write ? rd_onehot(wb_sel) : 32'd0;
    end

    // Write-back register stage. On idle cycles the address and data hold
    // so the register-file port does not toggle needlessly; an accepted
    // write to register 0 loads the stage but never raises reg_write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write  <= 1'b0;
            wb_sel     <= '0;
            wb_data    <= '0;
            wb_pending <= '0;
        end else begin
            reg_write  <= transfer && (sel_rd != REG_ZERO);
            wb_pending <= (wb_pending & ~pending_clr) | pending_set;
            if (transfer) begin
                wb_sel  <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of write-back requesters (legal 2..4).
REQ-002 The block SHALL have parameter XLEN, default 32, giving the data width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high; the ports are named clk and reset.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port req_valid, input, NUM_REQ: requester i has a write-back pending.
REQ-007 Port req_rd, input, NUM_REQ x 5: destination register per requester.
REQ-008 Port req_data, input, NUM_REQ x XLEN: write-back data per requester.
REQ-009 Port req_ready, output, NUM_REQ: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 Port reg_write, output, 1: register-file write enable.
REQ-011 Port wb_sel, output, 5: register-file write address.
REQ-012 Port wb_data, output, XLEN: register-file write data.
REQ-013 Port wb_pending, output, 32: per-register bit, high while a write to that register is granted but not yet presented.

Function
REQ-014 req_ready SHALL be combinational from req_valid and the priority state, with at most one bit high, and only for a valid requester.
REQ-015 When any req_valid is high, exactly one grant SHALL be issued that cycle (one transfer per cycle, no bubbles).
REQ-016 The accepted rd/data SHALL be registered; reg_write, wb_sel and wb_data SHALL appear on the cycle after the transfer (latency 1).
REQ-017 A transfer with rd = 0 SHALL drive reg_write = 0 on the following cycle; wb_sel and wb_data are don't-care in that cycle.
REQ-018 With no transfer in a cycle, reg_write SHALL be 0 on the next cycle, and wb_sel and wb_data SHALL hold their last values.
REQ-019 wb_pending[rd] SHALL be set on the transfer cycle and cleared when reg_write presents that write.
REQ-020 wb_pending[0] SHALL always be 0.
REQ-021 Two requesters targeting the same rd SHALL be written in grant order; the last grant wins.
REQ-022 A requester that deasserts req_valid without being granted SHALL lose its request with no side effect.
REQ-023 The arbitration policy SHALL be selected per REQ-026.

Reset
REQ-024 On reset assertion the block SHALL force the following, immediately and independently of clk:
- reg_write = 0, wb_sel = 0, wb_data = 0, wb_pending = 0;
- the priority pointer to requester 0.
REQ-025 Reset asserted mid-transfer SHALL discard the in-flight write: no reg_write is issued after reset is released.

Configuration
REQ-026 The arbitration policy SHALL be selected by macro WB_ARB_ROUND_ROBIN_EN:
- defined: round-robin. After a grant to i, the search SHALL start at i+1 mod NUM_REQ, and the pointer SHALL advance only on a transfer.
- undefined: fixed priority, lowest index wins, and the pointer logic SHALL be absent.

Structure
REQ-027 Shared package wb_arb_pkg SHALL hold:
- the requester index constants (REQ_ALU = 0, REQ_LSU = 1, REQ_CSR = 2);
- the typedef wb_req_t {rd[4:0], data[XLEN-1:0]};
- the constant REG_ZERO = 5'd0.
REQ-028 The grant logic SHALL be a sub-module rr_grant (request vector and pointer in, one-hot grant out), instantiated once.

Verification
REQ-029 Release reset, then raise req_valid = 3'b001 with rd = 5 and data = 0xDEADBEEF. Required response:
- req_ready = 001 on the same cycle;
- on the next cycle, reg_write = 1, wb_sel = 5, wb_data = 0xDEADBEEF;
- wb_pending[5] high for exactly one cycle.
REQ-030 Hold req_valid = 3'b111 for 6 cycles. Required response:
- round-robin: grants 0,1,2,0,1,2;
- fixed priority: 0 on all 6 cycles.
REQ-031 Send a single request with rd = 0 and data = 0x1234. Required response:
- req_ready is asserted;
- reg_write = 0 on the next cycle;
- wb_pending stays 0.
REQ-032 Requesters 1 and 2 both target rd = 7, with data 0xA and 0xB, under round-robin with the pointer at 1. Required response: the writes occur on consecutive cycles, and register 7's final data is 0xB.
REQ-033 Assert reset asynchronously (mid-cycle) in the cycle after a transfer with rd = 3. Required response:
- reg_write drops to 0 immediately;
- wb_pending = 0;
- the next grant after reset goes to requester 0.
REQ-034 Raise req_valid[2] for one cycle while req_valid[0] is also high, under fixed priority. Required response: requester 2 is never granted and no write with requester 2's data occurs.
